// File: rtl/multicycle_control.sv
// Moore control sequencer for the multicycle RV32I-subset core: steps each
// instruction through FETCH/DECODE/execute states and drives datapath selects.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       adrSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [1:0] aluOp,
  output logic [1:0] immSrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ILLEGAL  = 4'd11
  } stateT;

  localparam logic [6:0] opLw   = 7'b0000011;
  localparam logic [6:0] opSw   = 7'b0100011;
  localparam logic [6:0] opR    = 7'b0110011;
  localparam logic [6:0] opI    = 7'b0010011;
  localparam logic [6:0] opBeq  = 7'b1100011;
  localparam logic [6:0] opJal  = 7'b1101111;

  stateT curState, nextState;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) curState <= FETCH;
    else       curState <= nextState;
  end

  assign state = curState;

  always_comb begin
    nextState = curState;
    memReq    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    adrSrc    = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    resultSrc = 2'b00;
    aluOp     = 2'b00;
    illegal   = 1'b0;
    case (curState)
      FETCH: begin
        memReq    = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irWrite   = memReady;
        pcWrite   = memReady;
        if (memReady) nextState = DECODE;
      end
      // DECODE precomputes the branch/jump target into ALUOut while dispatching.
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          opLw, opSw: nextState = MEMADR;
          opR:        nextState = EXECR;
          opI:        nextState = EXECI;
          opBeq:      nextState = BEQ;
          opJal:      nextState = JAL;
          default:    nextState = ILLEGAL;
        endcase
      end
      MEMADR: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        nextState = (op == opLw) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        memReq = 1'b1;
        adrSrc = 1'b1;
        if (memReady) nextState = MEMWB;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        nextState = FETCH;
      end
      MEMWRITE: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        adrSrc   = 1'b1;
        if (memReady) nextState = FETCH;
      end
      EXECR: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b10;
        nextState = ALUWB;
      end
      EXECI: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        aluOp     = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        regWrite  = 1'b1;
        nextState = FETCH;
      end
      // ALUWB then writes the oldPC+4 link value computed here.
      JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pcWrite   = 1'b1;
        nextState = ALUWB;
      end
      BEQ: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b01;
        pcWrite   = zero;
        nextState = FETCH;
      end
      ILLEGAL: begin
        illegal   = 1'b1;
        nextState = ILLEGAL;
      end
      default: nextState = FETCH;
    endcase
    // Reset holds FETCH selects but must not let any strobe escape.
    if (reset) begin
      memReq   = 1'b0;
      memWrite = 1'b0;
      irWrite  = 1'b0;
      pcWrite  = 1'b0;
      regWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_comb begin
    case (op)
      opLw, opI: immSrc = 2'b00;
      opSw:      immSrc = 2'b01;
      opBeq:     immSrc = 2'b10;
      opJal:     immSrc = 2'b11;
      default:   immSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level traces are
// expanded into per-cycle expectations and checked by an independent monitor.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic       zero = 1'b0;
  logic       memReady = 1'b0;
  logic       memReq, memWrite, irWrite, pcWrite, regWrite, adrSrc, illegal;
  logic [1:0] aluSrcA, aluSrcB, resultSrc, aluOp, immSrc;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memReady(memReady),
    .memReq(memReq), .memWrite(memWrite), .irWrite(irWrite), .pcWrite(pcWrite),
    .regWrite(regWrite), .adrSrc(adrSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .resultSrc(resultSrc), .aluOp(aluOp), .immSrc(immSrc), .illegal(illegal),
    .state(state)
  );

  typedef struct packed {
    logic       memReq, memWrite, irWrite, pcWrite, regWrite, adrSrc;
    logic [1:0] aluSrcA, aluSrcB, resultSrc, aluOp, immSrc;
    logic       illegal;
  } outT;

  typedef struct packed {
    logic [3:0] st;
    outT        o;
  } expT;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  expT        expQ[$];
  int         checks = 0;
  int         errors = 0;
  int         cycleNo = 0;
  logic [6:0] curOp = 7'b0;
  logic [6:0] legalOps [6] = '{LW, SW, RT, IT, BQ, JL};

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic isLegal(logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
  endfunction

  function automatic logic [1:0] immOf(logic [6:0] o);
    if (o == LW || o == IT) return 2'b00;
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // Output table per visited state, straight from the state descriptions.
  function automatic outT model(int st, logic mr, logic z, logic rst, logic [6:0] o);
    outT e;
    e = '0;
    e.immSrc = immOf(o);
    if (rst) st = 0;
    case (st)
      0:  begin e.memReq = !rst; e.aluSrcB = 2'b10; e.resultSrc = 2'b10;
                e.irWrite = mr && !rst; e.pcWrite = mr && !rst; end
      1:  begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b01; end
      2:  begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; end
      3:  begin e.memReq = 1'b1; e.adrSrc = 1'b1; end
      4:  begin e.resultSrc = 2'b01; e.regWrite = 1'b1; end
      5:  begin e.memReq = 1'b1; e.memWrite = 1'b1; e.adrSrc = 1'b1; end
      6:  begin e.aluSrcA = 2'b10; e.aluOp = 2'b10; end
      7:  e.regWrite = 1'b1;
      8:  begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.aluOp = 2'b10; end
      9:  begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.pcWrite = 1'b1; end
      10: begin e.aluSrcA = 2'b10; e.aluOp = 2'b01; e.pcWrite = z; end
      11: e.illegal = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic applyStimulus(input int st, input logic mr, input logic z, input logic rst);
    expT e;
    @(negedge clk);
    reset    = rst;
    memReady = mr;
    zero     = z;
    op       = curOp;
    e.st = rst ? 4'd0 : 4'(st);
    e.o  = model(st, mr, z, rst, curOp);
    expQ.push_back(e);
  endtask

  // One whole instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic runInstr(input logic [6:0] o, input int fw, input int mw, input logic bz);
    curOp = o;
    for (int i = 0; i < fw; i++) applyStimulus(0, 1'b0, rb(), 1'b0);
    applyStimulus(0, 1'b1, rb(), 1'b0);
    applyStimulus(1, rb(), rb(), 1'b0);
    if (o == LW) begin
      applyStimulus(2, rb(), rb(), 1'b0);
      for (int i = 0; i < mw; i++) applyStimulus(3, 1'b0, rb(), 1'b0);
      applyStimulus(3, 1'b1, rb(), 1'b0);
      applyStimulus(4, rb(), rb(), 1'b0);
    end else if (o == SW) begin
      applyStimulus(2, rb(), rb(), 1'b0);
      for (int i = 0; i < mw; i++) applyStimulus(5, 1'b0, rb(), 1'b0);
      applyStimulus(5, 1'b1, rb(), 1'b0);
    end else if (o == RT) begin
      applyStimulus(6, rb(), rb(), 1'b0);
      applyStimulus(7, rb(), rb(), 1'b0);
    end else if (o == IT) begin
      applyStimulus(8, rb(), rb(), 1'b0);
      applyStimulus(7, rb(), rb(), 1'b0);
    end else if (o == JL) begin
      applyStimulus(9, rb(), rb(), 1'b0);
      applyStimulus(7, rb(), rb(), 1'b0);
    end else if (o == BQ) begin
      applyStimulus(10, rb(), bz, 1'b0);
    end else begin
      for (int i = 0; i < 20; i++) applyStimulus(11, rb(), rb(), 1'b0);
      applyStimulus(0, rb(), rb(), 1'b1);
    end
  endtask

  task automatic checkOutput(input expT e);
    outT got;
    got = {memReq, memWrite, irWrite, pcWrite, regWrite, adrSrc,
           aluSrcA, aluSrcB, resultSrc, aluOp, immSrc, illegal};
    checks++;
    if (state !== e.st) begin
      errors++;
      $display("[TB] FAIL state cycle %0d: got %0d want %0d", cycleNo, state, e.st);
    end
    checks++;
    if (got !== e.o) begin
      errors++;
      $display("[TB] FAIL outputs cycle %0d (state %0d): got %h want %h",
               cycleNo, e.st, got, e.o);
    end
    cycleNo++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    logic [6:0] o;
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    // Reset in the middle of a stalled load.
    curOp = LW;
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    applyStimulus(3, 1'b0, 1'b0, 1'b0);
    applyStimulus(3, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    runInstr(LW, 0, 0, 1'b0);
    runInstr(SW, 0, 3, 1'b0);
    runInstr(BQ, 0, 0, 1'b1);
    runInstr(BQ, 0, 0, 1'b0);
    runInstr(JL, 0, 0, 1'b0);
    runInstr(RT, 0, 0, 1'b0);
    runInstr(IT, 2, 0, 1'b0);
    runInstr(7'b1111111, 0, 0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        do o = 7'($urandom); while (isLegal(o));
      end else begin
        o = legalOps[$urandom_range(0, 5)];
      end
      runInstr(o, $urandom_range(0, 3), $urandom_range(0, 3), rb());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control sequencer for the multicycle RISC-V core (RV32I subset: lw, sw, R-type, I-type ALU, beq, jal). It replaces the single-cycle main decoder when the datapath shares one memory port and one ALU across cycles. It steps each instruction through a Moore FSM and drives the datapath mux selects and write strobes. It also handshakes with the unified instruction/data memory through `memReq`/`memReady`.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; forces the FSM to FETCH.
- `op` input 7: opcode from the instruction register (IR), valid from DECODE onward.
- `zero` input 1: ALU zero flag.
- `memReady` input 1: memory completed the current access this cycle.
- `memReq` output 1: memory access requested.
- `memWrite` output 1: write enable to memory.
- `irWrite` output 1: load the IR and the old-PC register.
- `pcWrite` output 1: load the PC.
- `regWrite` output 1: register-file write enable.
- `adrSrc` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `aluSrcA` output 2: ALU operand A select; 00 = PC, 01 = oldPC, 10 = rs1 register A.
- `aluSrcB` output 2: ALU operand B select; 00 = register B, 01 = immediate, 10 = constant 4.
- `resultSrc` output 2: result select; 00 = ALUOut, 01 = memory data register, 10 = live ALU result.
- `aluOp` output 2: to the ALU decoder; 00 = add, 01 = subtract (compare), 10 = decode by funct.
- `immSrc` output 2: to the immediate extender; 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal` output 1: sticky flag for an unsupported opcode.
- `state` output 4: current state encoding, for debug.

## Operation
- State encodings (4 bits):
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECR = 6, ALUWB = 7, EXECI = 8, JAL = 9, BEQ = 10, ILLEGAL = 11
- Default outputs are 0 unless listed for a state.
- FETCH
  - Outputs: `memReq`=1, `adrSrc`=0, `aluSrcA`=00, `aluSrcB`=10, `aluOp`=00, `resultSrc`=10.
  - `irWrite` = `pcWrite` = `memReady`.
  - Go to DECODE when `memReady`=1; otherwise stay.
- DECODE
  - Outputs: `aluSrcA`=01, `aluSrcB`=01, `aluOp`=00 (precompute branch/jump target into ALUOut).
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECR
    - 0010011 (I-type ALU) → EXECI
    - 1100011 (beq) → BEQ
    - 1101111 (jal) → JAL
    - any other opcode → ILLEGAL
- MEMADR
  - Outputs: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=00.
  - Go to MEMREAD if op = lw, else MEMWRITE.
- MEMREAD
  - Outputs: `memReq`=1, `adrSrc`=1, `resultSrc`=00.
  - Stay until `memReady`=1, then go to MEMWB.
- MEMWB: `resultSrc`=01, `regWrite`=1; go to FETCH.
- MEMWRITE
  - Outputs: `memReq`=1, `memWrite`=1, `adrSrc`=1, `resultSrc`=00.
  - Stay until `memReady`=1, then go to FETCH.
- EXECR: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=10; go to ALUWB.
- EXECI: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=10; go to ALUWB.
- ALUWB: `resultSrc`=00, `regWrite`=1; go to FETCH.
- JAL
  - Outputs: `aluSrcA`=01, `aluSrcB`=10, `aluOp`=00, `resultSrc`=00, `pcWrite`=1.
  - Go to ALUWB, which writes oldPC+4 to rd.
- BEQ
  - Outputs: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=01, `resultSrc`=00.
  - `pcWrite` = `zero`.
  - Go to FETCH.
- ILLEGAL: all strobes 0, `illegal`=1; absorbing state, left only by reset.
- `immSrc` is combinational from `op` in every state:
  - lw or I-type → 00; sw → 01; beq → 10; jal → 11; anything else → 00.

## Timing
- Registered: the state register only. All other outputs are combinational from `state`, plus `op`, `zero` and `memReady` where listed above.
- Reset
  - While `reset`=1: `state`=FETCH.
  - `memReq`, `memWrite`, `irWrite`, `pcWrite`, `regWrite` and `illegal` are forced to 0.
  - Mux selects take their FETCH values.
  - First fetch request is issued in the first cycle after reset deasserts.
- Reset mid-instruction (including during a memory wait): the FSM returns to FETCH immediately and no strobe fires afterwards.
- Latency with `memReady` held at 1:
  - lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.
- Each cycle of memory wait in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Wait-state rules:
  - `memReq` and the address select stay stable throughout the wait.
  - `irWrite` and `pcWrite` are asserted only in the cycle where `memReady`=1.
  - `memWrite` is held for the whole MEMWRITE dwell.
- `memReady` outside FETCH, MEMREAD and MEMWRITE is ignored.
- `pcWrite` and `regWrite` are never both asserted in MEMWB.
- Exactly one `regWrite` pulse per lw, R-type, I-type and jal instruction; none for sw or beq.

## Test plan
- Reset asserted mid-MEMREAD with `memReady`=0 → `state`=0 asynchronously, all strobes 0; first FETCH after release asserts `memReq`=1.
- lw (op=0000011) with `memReady`=1 → states 0,1,2,3,4,0; `regWrite`=1 only in state 4 with `resultSrc`=01; `immSrc`=00.
- sw with `memReady` low for 3 cycles in MEMWRITE → `memWrite`=1 for 4 consecutive cycles, `adrSrc`=1, then FETCH; `regWrite` stays 0.
- beq twice (`zero`=1, then `zero`=0) → states 0,1,10,0 each time; `pcWrite` in BEQ is 1 then 0; `aluOp`=01; `immSrc`=10.
- jal then R-type → jal: states 0,1,9,7,0 with `pcWrite`=1 in 9 and `regWrite`=1 in 7; R-type: states 0,1,6,7,0 with `aluOp`=10 in 6.
- op=1111111 → DECODE goes to ILLEGAL (11); `illegal`=1 and holds for 20 cycles with no strobes; reset clears it.
